// File: rtl/canal_pkg.sv
// Shared types and default timing constants for the canal-lock pipeline
// (lock sequencer and water-level stage).
package canal_pkg;

    typedef enum logic [2:0] {
        LOW_IDLE,
        LOW_OPEN,
        RAISING,
        HIGH_IDLE,
        HIGH_OPEN,
        LOWERING,
        FAULT
    } lock_state_t;

    typedef enum logic {
        LOW,
        HIGH
    } side_t;

    localparam int unsigned GATE_MIN_DEF      = 20;
    localparam int unsigned GATE_TIMEOUT_DEF  = 200;
    localparam int unsigned WATER_TIMEOUT_DEF = 127;
    localparam int unsigned CW_DEF            = 8;

endpackage

// File: rtl/lock_sequencer_if.sv
// Boat requests, water-stage handshake and gate/status outputs of the lock sequencer.
// master: the sequencer; slave: the surrounding environment / water stage.
interface lock_sequencer_if;

    logic boat_low;
    logic boat_high;
    logic boat_clear;
    logic water_high;
    logic water_low;
    logic w_up;
    logic w_down;
    logic gate_low_open;
    logic gate_high_open;
    logic occupied;
    logic timeout;
    logic fault;

    modport master (
        input  boat_low,
        input  boat_high,
        input  boat_clear,
        input  water_high,
        input  water_low,
        output w_up,
        output w_down,
        output gate_low_open,
        output gate_high_open,
        output occupied,
        output timeout,
        output fault
    );

    modport slave (
        output boat_low,
        output boat_high,
        output boat_clear,
        output water_high,
        output water_low,
        input  w_up,
        input  w_down,
        input  gate_low_open,
        input  gate_high_open,
        input  occupied,
        input  timeout,
        input  fault
    );

endinterface

// File: rtl/lock_timer.sv
// Clearable, saturating up-counter shared between gate and water timing.
// Clear wins over enable; the count holds at all-ones instead of wrapping.
module lock_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/lock_sequencer.sv
// Canal-lock sequencing FSM: serves boats at either side, drives the gates and
// issues one-cycle raise/lower commands to the downstream water-level stage.
module lock_sequencer
    import canal_pkg::*;
#(
    parameter int unsigned GATE_MIN      = GATE_MIN_DEF,
    parameter int unsigned GATE_TIMEOUT  = GATE_TIMEOUT_DEF,
    parameter int unsigned WATER_TIMEOUT = WATER_TIMEOUT_DEF,
    parameter int unsigned CW            = CW_DEF
) (
    input logic                clk,
    input logic                reset,
    lock_sequencer_if.master   bus
);

    localparam logic [CW-1:0] GATE_MIN_M1      = CW'(GATE_MIN - 1);
    localparam logic [CW-1:0] GATE_TIMEOUT_M1  = CW'(GATE_TIMEOUT - 1);
    localparam logic [CW-1:0] WATER_TIMEOUT_M1 = CW'(WATER_TIMEOUT - 1);

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    side_t       r_last;
    side_t       w_last_nxt;
    logic        r_occ;
    logic        w_occ_nxt;
    logic        r_cleared;
    logic        w_cleared_nxt;
    logic        w_timeout_nxt;
    logic        w_clr_seen;
    logic        w_entry;
    logic        w_tmr_en;
    logic [CW-1:0] w_count;

    logic r_w_up;
    logic r_w_down;
    logic r_gate_low;
    logic r_gate_high;
    logic r_timeout;
    logic r_fault;

    // One timer, cleared on every state change, so each timed state starts from 0.
    lock_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_entry),
        .i_enable (w_tmr_en),
        .o_count  (w_count)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_occ_nxt     = r_occ;
        w_cleared_nxt = r_cleared;
        w_timeout_nxt = 1'b0;
        w_clr_seen    = r_cleared | bus.boat_clear;
        w_tmr_en      = (r_state == LOW_OPEN) || (r_state == HIGH_OPEN) ||
                        (r_state == RAISING)  || (r_state == LOWERING);

        unique case (r_state)
            LOW_IDLE: begin
                if (r_occ) begin
                    w_state_nxt = LOW_OPEN;
                end else if (bus.boat_low && (!bus.boat_high || r_last == HIGH)) begin
                    w_state_nxt = LOW_OPEN;
                end else if (bus.boat_high) begin
                    w_state_nxt = RAISING;
                end
            end
            HIGH_IDLE: begin
                if (r_occ) begin
                    w_state_nxt = HIGH_OPEN;
                end else if (bus.boat_high && (!bus.boat_low || r_last == LOW)) begin
                    w_state_nxt = HIGH_OPEN;
                end else if (bus.boat_low) begin
                    w_state_nxt = LOWERING;
                end
            end
            LOW_OPEN, HIGH_OPEN: begin
                // Only the first clear of a visit moves the boat in or out.
                if (bus.boat_clear && !r_cleared) begin
                    w_cleared_nxt = 1'b1;
                    w_occ_nxt     = ~r_occ;
                end
                if ((w_count >= GATE_MIN_M1) && w_clr_seen) begin
                    if (r_state == LOW_OPEN) begin
                        w_state_nxt = w_occ_nxt ? RAISING : LOW_IDLE;
                    end else begin
                        w_state_nxt = w_occ_nxt ? LOWERING : HIGH_IDLE;
                    end
                end else if ((w_count == GATE_TIMEOUT_M1) && !w_clr_seen) begin
                    w_timeout_nxt = 1'b1;
                    if (r_state == LOW_OPEN) begin
                        w_state_nxt = r_occ ? RAISING : LOW_IDLE;
                    end else begin
                        w_state_nxt = r_occ ? LOWERING : HIGH_IDLE;
                    end
                end
            end
            RAISING: begin
                if (bus.water_high) begin
                    w_state_nxt = HIGH_IDLE;
                end else if (w_count >= WATER_TIMEOUT_M1) begin
                    w_state_nxt = FAULT;
                end
            end
            LOWERING: begin
                if (bus.water_low) begin
                    w_state_nxt = LOW_IDLE;
                end else if (w_count >= WATER_TIMEOUT_M1) begin
                    w_state_nxt = FAULT;
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = LOW_IDLE;
            end
        endcase

        w_entry = (w_state_nxt != r_state);
        if (w_entry) begin
            w_cleared_nxt = 1'b0;
            if (w_state_nxt == LOW_OPEN) begin
                w_last_nxt = LOW;
            end else if (w_state_nxt == HIGH_OPEN) begin
                w_last_nxt = HIGH;
            end
        end
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOW_IDLE;
            r_last      <= HIGH;
            r_occ       <= 1'b0;
            r_cleared   <= 1'b0;
            r_w_up      <= 1'b0;
            r_w_down    <= 1'b0;
            r_gate_low  <= 1'b0;
            r_gate_high <= 1'b0;
            r_timeout   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_occ       <= w_occ_nxt;
            r_cleared   <= w_cleared_nxt;
            r_w_up      <= w_entry && (w_state_nxt == RAISING);
            r_w_down    <= w_entry && (w_state_nxt == LOWERING);
            r_gate_low  <= (w_state_nxt == LOW_OPEN);
            r_gate_high <= (w_state_nxt == HIGH_OPEN);
            r_timeout   <= w_timeout_nxt;
            r_fault     <= (w_state_nxt == FAULT);
        end
    end

    assign bus.w_up           = r_w_up;
    assign bus.w_down         = r_w_down;
    assign bus.gate_low_open  = r_gate_low;
    assign bus.gate_high_open = r_gate_high;
    assign bus.occupied       = r_occ;
    assign bus.timeout        = r_timeout;
    assign bus.fault          = r_fault;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: one task per scenario, hand-computed expectations.
module tb_lock_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [6:0] outs;

    lock_sequencer_if bus ();

    lock_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.w_up, bus.w_down, bus.gate_low_open, bus.gate_high_open,
                   bus.occupied, bus.timeout, bus.fault};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.boat_low = 1'b0; bus.boat_high = 1'b0; bus.boat_clear = 1'b0;
        bus.water_high = 1'b0; bus.water_low = 1'b0;
        tick(3);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL reset_outs: got %b want 0000000", outs); end
        reset = 1'b0;
        tick(2);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL idle_outs: got %b want 0000000", outs); end
    endtask

    task automatic test_low_service();
        int ups;
        bus.boat_low = 1'b1;
        tick(1);                                   // LOW_OPEN cycle 0
        n_cmp++; if (bus.gate_low_open !== 1'b1) begin n_err++; $display("FAIL t1_gate_low_rise: got %b want 1", bus.gate_low_open); end
        n_cmp++; if (bus.gate_high_open !== 1'b0) begin n_err++; $display("FAIL t1_gate_high_closed: got %b want 0", bus.gate_high_open); end
        bus.boat_low = 1'b0;
        tick(5);                                   // cycle 5
        bus.boat_clear = 1'b1;
        tick(1);                                   // cycle 6
        bus.boat_clear = 1'b0;
        n_cmp++; if (bus.occupied !== 1'b1) begin n_err++; $display("FAIL t1_occ_in: got %b want 1", bus.occupied); end
        tick(13);                                  // cycle 19
        n_cmp++; if (bus.gate_low_open !== 1'b1) begin n_err++; $display("FAIL t1_gate_min_open: got %b want 1", bus.gate_low_open); end
        tick(1);                                   // cycle 20 = RAISING cycle 0
        n_cmp++; if (bus.gate_low_open !== 1'b0) begin n_err++; $display("FAIL t1_gate_min_close: got %b want 0", bus.gate_low_open); end
        n_cmp++; if (bus.w_up !== 1'b1) begin n_err++; $display("FAIL t1_wup: got %b want 1", bus.w_up); end
        ups = 0;
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            ups += int'(bus.w_up);
        end
        n_cmp++; if (ups !== 0) begin n_err++; $display("FAIL t1_wup_once: got %0d extra pulses want 0", ups); end
        bus.water_high = 1'b1;                     // RAISING cycle 80
        tick(1);                                   // HIGH_IDLE
        bus.water_high = 1'b0;
        tick(1);                                   // HIGH_OPEN cycle 0
        n_cmp++; if (bus.gate_high_open !== 1'b1) begin n_err++; $display("FAIL t1_gate_high_open: got %b want 1", bus.gate_high_open); end
        bus.boat_clear = 1'b1;
        tick(1);                                   // cycle 1
        bus.boat_clear = 1'b0;
        n_cmp++; if (bus.occupied !== 1'b0) begin n_err++; $display("FAIL t1_occ_out: got %b want 0", bus.occupied); end
        tick(2);                                   // cycle 3: second clear must be ignored
        bus.boat_clear = 1'b1;
        tick(1);
        bus.boat_clear = 1'b0;
        n_cmp++; if (bus.occupied !== 1'b0) begin n_err++; $display("FAIL t1_second_clear: got %b want 0", bus.occupied); end
        tick(16);                                  // cycle 20 -> HIGH_IDLE
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t1_high_idle: got %b want 0000000", outs); end
    endtask

    task automatic test_lowering();
        bus.boat_low = 1'b1;
        tick(1);                                   // LOWERING cycle 0
        n_cmp++; if (outs !== 7'b0100000) begin n_err++; $display("FAIL t2_wdown: got %b want 0100000", outs); end
        tick(1);
        n_cmp++; if (bus.w_down !== 1'b0) begin n_err++; $display("FAIL t2_wdown_once: got %b want 0", bus.w_down); end
        bus.water_low = 1'b1;
        tick(1);                                   // LOW_IDLE
        bus.water_low = 1'b0;
        n_cmp++; if (bus.gate_low_open !== 1'b0) begin n_err++; $display("FAIL t2_low_idle: got %b want 0", bus.gate_low_open); end
        tick(1);                                   // LOW_OPEN cycle 0
        n_cmp++; if (bus.gate_low_open !== 1'b1) begin n_err++; $display("FAIL t2_reopen: got %b want 1", bus.gate_low_open); end
        bus.boat_low = 1'b0;
    endtask

    task automatic test_gate_timeout();
        tick(199);                                 // LOW_OPEN cycle 199
        n_cmp++; if (outs !== 7'b0010000) begin n_err++; $display("FAIL t3_open_199: got %b want 0010000", outs); end
        tick(1);                                   // LOW_IDLE
        n_cmp++; if (outs !== 7'b0000010) begin n_err++; $display("FAIL t3_timeout: got %b want 0000010", outs); end
        tick(1);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t3_timeout_pulse: got %b want 0000000", outs); end
    endtask

    task automatic test_tie();
        reset = 1'b1;
        bus.boat_low = 1'b1; bus.boat_high = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);                                   // low side served first
        n_cmp++; if (outs !== 7'b0010000) begin n_err++; $display("FAIL t4_first_low: got %b want 0010000", outs); end
        tick(200);                                 // timeout back to LOW_IDLE
        n_cmp++; if (bus.timeout !== 1'b1) begin n_err++; $display("FAIL t4_timeout: got %b want 1", bus.timeout); end
        tick(1);                                   // tie again -> high served
        n_cmp++; if (outs !== 7'b1000000) begin n_err++; $display("FAIL t4_second_high: got %b want 1000000", outs); end
        bus.boat_low = 1'b0; bus.boat_high = 1'b0;
    endtask

    task automatic test_water_fault();
        for (int c = 1; c <= 126; c++) begin
            tick(1);
            bus.water_low = (c == 10 || c == 50);
        end
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t5_raise_126: got %b want 0000000", outs); end
        tick(1);                                   // RAISING cycle 127 -> FAULT
        bus.water_low = 1'b0;
        n_cmp++; if (outs !== 7'b0000001) begin n_err++; $display("FAIL t5_fault: got %b want 0000001", outs); end
        bus.boat_low = 1'b1;
        tick(10);
        n_cmp++; if (outs !== 7'b0000001) begin n_err++; $display("FAIL t5_fault_sticky: got %b want 0000001", outs); end
        bus.boat_low = 1'b0;
        reset = 1'b1;
        tick(1);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t5_fault_reset: got %b want 0000000", outs); end
        reset = 1'b0;
        tick(2);
        bus.boat_low = 1'b1;
        tick(1);                                   // LOW_IDLE proven by immediate low opening
        n_cmp++; if (outs !== 7'b0010000) begin n_err++; $display("FAIL t5_post_reset_low: got %b want 0010000", outs); end
        bus.boat_low = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick(1);                                   // LOW_OPEN cycle 1
        reset = 1'b1;
        bus.boat_clear = 1'b1;
        tick(1);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t6_reset_mid: got %b want 0000000", outs); end
        reset = 1'b0;
        bus.boat_clear = 1'b0;
        tick(3);
        n_cmp++; if (outs !== 7'b0) begin n_err++; $display("FAIL t6_after_reset: got %b want 0000000", outs); end
    endtask

    task automatic test_clear_on_timeout();
        bus.boat_low = 1'b1;
        tick(1);                                   // LOW_OPEN cycle 0
        bus.boat_low = 1'b0;
        tick(199);                                 // cycle 199: clear on the timeout cycle
        bus.boat_clear = 1'b1;
        tick(1);
        bus.boat_clear = 1'b0;
        n_cmp++; if (outs !== 7'b1000100) begin n_err++; $display("FAIL t7_clear_on_timeout: got %b want 1000100", outs); end
    endtask

    initial begin
        test_reset();
        test_low_service();
        test_lowering();
        test_gate_timeout();
        test_tie();
        test_water_fault();
        test_reset_mid();
        test_clear_on_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Canal-lock sequencing FSM directly upstream of the water-level stage.
- Services boats waiting at the low or high side: opens/closes the low and high gates, tracks lock occupancy, and issues one-cycle w_up/w_down commands to the water stage.
- Consumes the water stage's water_high/water_low completion flags.
- Reset is shared with the water stage, so both start at "low water".

Parameters:
- GATE_MIN, 20: minimum cycles a gate stays open.
- GATE_TIMEOUT, 200: cycles an open gate waits for boat_clear before closing anyway.
- WATER_TIMEOUT, 127: cycles allowed for a raise/lower before declaring a fault.
- CW, 8: timer width; must hold max(GATE_TIMEOUT, WATER_TIMEOUT).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- boat_low  in  1  level: boat waiting outside the low gate
- boat_high  in  1  level: boat waiting outside the high gate
- boat_clear  in  1  one-cycle pulse: a boat fully passed the currently open gate
- water_high  in  1  water stage: raise complete (transient, valid only while raising)
- water_low  in  1  water stage: lower complete (transient; may also assert late in a raise)
- w_up  out  1  one-cycle raise command
- w_down  out  1  one-cycle lower command
- gate_low_open  out  1  low gate open
- gate_high_open  out  1  high gate open
- occupied  out  1  boat inside the lock
- timeout  out  1  one-cycle pulse: gate closed on GATE_TIMEOUT
- fault  out  1  sticky water-timeout fault

Behaviour:
- All outputs are registered (Moore). On reset, every output is 0, the state is LOW_IDLE, and last_served = HIGH.
- Reset mid-operation aborts immediately to the reset state, regardless of gate or water activity.
- States: LOW_IDLE, LOW_OPEN, RAISING, HIGH_IDLE, HIGH_OPEN, LOWERING, FAULT.
- LOW_IDLE transitions:
  - occupied=1 -> LOW_OPEN (let the boat out).
  - Else, request selection:
    - Only boat_low -> LOW_OPEN.
    - Only boat_high -> RAISING (fetch with an empty lock).
    - Both -> serve the side != last_served.
  - Else stay.
- HIGH_IDLE: mirror of LOW_IDLE (occupied or boat_high -> HIGH_OPEN; boat_low -> LOWERING).
- Entering any OPEN state sets last_served to that side.
- LOW_OPEN/HIGH_OPEN:
  - gate_*_open=1 for the whole state; the timer clears on entry.
  - boat_clear toggles occupied, at most once per OPEN visit; further pulses are ignored.
  - Exit when timer >= GATE_MIN-1 and a clear has been seen, or when timer == GATE_TIMEOUT-1 with no clear.
  - A timeout exit pulses timeout for 1 cycle and leaves occupied unchanged.
  - boat_clear arriving on the timeout cycle counts as a clear, with no timeout pulse.
  - On exit from LOW_OPEN: occupied=1 -> RAISING, else LOW_IDLE.
  - On exit from HIGH_OPEN: occupied=1 -> LOWERING, else HIGH_IDLE.
- RAISING:
  - w_up=1 only in the first cycle of the state.
  - Next state HIGH_IDLE on the first cycle water_high=1; water_low is ignored.
  - Timer reaching WATER_TIMEOUT -> FAULT.
- LOWERING:
  - w_down=1 only in the first cycle; exit to LOW_IDLE on water_low=1; water_high is ignored; same timeout rule.
- FAULT: gates closed, no commands, fault=1; exit only via reset.
- Gates are mutually exclusive: never both open; neither open during RAISING/LOWERING.
- boat_clear outside an OPEN state is ignored.
- Request inputs are sampled only in IDLE states.
- The timer saturates at all-ones; it never wraps.

Decomposition:
- Shared package canal_pkg holds:
  - the state enum lock_state_t,
  - the side enum side_t {LOW, HIGH},
  - default parameter constants, shared with the water stage.
- One sub-module, lock_timer: a clearable saturating CW-bit up-counter with clear/enable inputs and count output. It is used once and muxed between the gate and water timing roles.

Test Plan:
1. Reset, boat_low=1 -> gate_low_open rises 1 cycle later. Then:
   - boat_clear at open-cycle 5: gate closes at open-cycle 20 (GATE_MIN), occupied=1, w_up pulses once.
   - water_high at RAISING cycle 80: HIGH_OPEN next cycle.
   - boat_clear: occupied=0, HIGH_IDLE.
2. From HIGH_IDLE, assert boat_low only -> w_down pulse, LOWERING. water_low asserted -> LOW_IDLE, then LOW_OPEN only if boat_low is still high.
3. LOW_OPEN with no boat_clear -> gate closes after exactly 200 cycles, timeout pulses 1 cycle, occupied unchanged, state LOW_IDLE.
4. boat_low and boat_high both held in LOW_IDLE after reset -> low served first. Next tie in LOW_IDLE -> RAISING (high served).
5. In RAISING, hold water_high=0 while pulsing water_low -> no transition; after 127 cycles, fault=1 sticky, gates closed. reset -> all outputs 0, LOW_IDLE.
6. Assert reset during LOW_OPEN with a boat_clear on the same cycle -> next cycle all outputs 0, occupied=0, no w_up.
